// File: rtl/logic_unit_pipe.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : logic_unit_pipe
// Description : Two-stage pipelined WIDTH-bit bitwise logic unit. The op
//               select picks NOT/AND/OR/XOR/NAND/NOR/XNOR; op 7 is flagged
//               as an error. Each result carries zero, all-ones and parity
//               flags. Valid/ready flow control is used on both sides, and
//               a wrapping count of delivered results is kept.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic             out_ones,
  output logic             out_par,
  output logic             out_err,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [2:0] c_OP_NOT  = 3'd0;
  localparam logic [2:0] c_OP_AND  = 3'd1;
  localparam logic [2:0] c_OP_OR   = 3'd2;
  localparam logic [2:0] c_OP_XOR  = 3'd3;
  localparam logic [2:0] c_OP_NAND = 3'd4;
  localparam logic [2:0] c_OP_NOR  = 3'd5;
  localparam logic [2:0] c_OP_XNOR = 3'd6;

  // Stage 1: captured operands
  logic             r_s1_valid;
  logic [2:0]       r_s1_op;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;

  // Stage 2: registered result and flags
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_y;
  logic             r_s2_zero;
  logic             r_s2_ones;
  logic             r_s2_par;
  logic             r_s2_err;

  logic [CNT_W-1:0] r_op_count;

  // Combinational function/flag results between the stages
  logic             w_s2_adv;
  logic             w_s1_adv;
  logic [WIDTH-1:0] w_y;
  logic             w_err;
  logic             w_zero;
  logic             w_ones;
  logic             w_par;

  // A stage may load when it is empty or its contents move on this cycle.
  // in_ready therefore follows out_ready combinationally (no skid buffer).
  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv && !rst;

  // Bitwise function select; illegal op forces a zero result with error
  always_comb begin
    w_y   = '0;
    w_err = 1'b0;
    case (r_s1_op)
      c_OP_NOT:  w_y = ~r_s1_a;
      c_OP_AND:  w_y = r_s1_a & r_s1_b;
      c_OP_OR:   w_y = r_s1_a | r_s1_b;
      c_OP_XOR:  w_y = r_s1_a ^ r_s1_b;
      c_OP_NAND: w_y = ~(r_s1_a & r_s1_b);
      c_OP_NOR:  w_y = ~(r_s1_a | r_s1_b);
      c_OP_XNOR: w_y = ~(r_s1_a ^ r_s1_b);
      default: begin
        w_y   = '0;
        w_err = 1'b1;
      end
    endcase
  end

  // Flags describe the result that is actually presented, so the illegal
  // case naturally yields zero=1, ones=0, par=0.
  assign w_zero = (w_y == '0);
  assign w_ones = &w_y;
  assign w_par  = ^w_y;

  // Stage 1 register: accept a new beat whenever stage 1 can advance
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      r_s1_op    <= in_op;
      r_s1_a     <= in_a;
      r_s1_b     <= in_b;
    end
  end

  // Stage 2 register: holds result and flags steady while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_y     <= '0;
      r_s2_zero  <= 1'b0;
      r_s2_ones  <= 1'b0;
      r_s2_par   <= 1'b0;
      r_s2_err   <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      r_s2_y     <= w_y;
      r_s2_zero  <= w_zero;
      r_s2_ones  <= w_ones;
      r_s2_par   <= w_par;
      r_s2_err   <= w_err;
    end
  end

  // Count output handshakes; wraps silently at the counter width
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_count <= '0;
    end else if (r_s2_valid && out_ready) begin
      r_op_count <= r_op_count + 1'b1;
    end
  end

  assign out_valid = r_s2_valid;
  assign out_y     = r_s2_y;
  assign out_zero  = r_s2_zero;
  assign out_ones  = r_s2_ones;
  assign out_par   = r_s2_par;
  assign out_err   = r_s2_err;
  assign op_count  = r_op_count;

endmodule
`default_nettype wire
